cheshire_reg_demux: RTL and testbench

CHESHIRE_REG_DEMUX -- requirements
Module: cheshire_reg_demux

---
 rtl/cheshire_reg_demux.sv | 172 +++++++++++++++++
 tb/tb_cheshire_reg_demux.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cheshire_reg_demux.sv
// Register-bus demultiplexer: routes one request at a time to the port picked by an address map.
// Defining CHESHIRE_REG_DEMUX_TIMEOUT_EN adds a forward-phase timeout counter.
module cheshire_reg_demux #(
  parameter int unsigned NumOut        = 11,
  parameter int unsigned NumRules      = 11,
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NumRules-1:0][32+2*AddrWidth-1:0]   addr_map_i,
  input  logic [AddrWidth-1:0]                      in_addr_i,
  input  logic                                      in_write_i,
  input  logic [DataWidth-1:0]                      in_wdata_i,
  input  logic [DataWidth/8-1:0]                    in_wstrb_i,
  input  logic                                      in_valid_i,
  output logic [DataWidth-1:0]                      in_rdata_o,
  output logic                                      in_error_o,
  output logic                                      in_ready_o,
  output logic [AddrWidth-1:0]                      out_addr_o,
  output logic                                      out_write_o,
  output logic [DataWidth-1:0]                      out_wdata_o,
  output logic [DataWidth/8-1:0]                    out_wstrb_o,
  output logic [NumOut-1:0]                         out_valid_o,
  input  logic [NumOut-1:0][DataWidth-1:0]          out_rdata_i,
  input  logic [NumOut-1:0]                         out_error_i,
  input  logic [NumOut-1:0]                         out_ready_i,
  output logic                                      timeout_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned SelWidth  = (NumOut > 1) ? $clog2(NumOut) : 1;

  typedef enum logic [1:0] {IDLE, FWD, RSP} state_e;

  state_e                              state_q, state_d;
  logic [AddrWidth-1:0]                addr_q;
  logic                                write_q;
  logic [DataWidth-1:0]                wdata_q;
  logic [StrbWidth-1:0]                wstrb_q;
  logic [SelWidth-1:0]                 sel_q;
  logic [DataWidth-1:0]                rdata_q;
  logic                                error_q;

  logic [NumRules-1:0][31:0]           rule_idx;
  logic [NumRules-1:0][AddrWidth-1:0]  rule_start;
  logic [NumRules-1:0][AddrWidth-1:0]  rule_end;
  logic                                dec_hit;
  logic [SelWidth-1:0]                 dec_sel;
  logic                                sel_ready;
  logic                                sel_error;
  logic [DataWidth-1:0]                sel_rdata;
  logic                                expired;

  always_comb begin
    for (int unsigned r = 0; r < NumRules; r++) begin
      rule_idx[r]   = addr_map_i[r][32+2*AddrWidth-1 -: 32];
      rule_start[r] = addr_map_i[r][2*AddrWidth-1 -: AddrWidth];
      rule_end[r]   = addr_map_i[r][AddrWidth-1:0];
    end
  end

  // Later rules overwrite earlier ones, so the highest-numbered match decides hit or miss.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int unsigned r = 0; r < NumRules; r++) begin
      if (rule_start[r] < rule_end[r] &&
          in_addr_i >= rule_start[r] && in_addr_i < rule_end[r]) begin
        dec_hit = (rule_idx[r] < NumOut);
        dec_sel = rule_idx[r][SelWidth-1:0];
      end
    end
  end

  always_comb begin
    out_valid_o = '0;
    sel_ready   = 1'b0;
    sel_error   = 1'b0;
    sel_rdata   = '0;
    for (int unsigned p = 0; p < NumOut; p++) begin
      if (state_q == FWD && sel_q == SelWidth'(p)) begin
        out_valid_o[p] = 1'b1;
        sel_ready      = out_ready_i[p];
        sel_error      = out_error_i[p];
        sel_rdata      = out_rdata_i[p];
      end
    end
  end

`ifdef CHESHIRE_REG_DEMUX_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TimeoutCycles);

  logic [CntWidth-1:0] cnt_q;
  logic                timeout_q;

  // Counts FWD cycles without ready; a ready in the final cycle still wins.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= (state_q == FWD && !sel_ready) ? cnt_q + 1'b1 : '0;
      timeout_q <= expired && !sel_ready;
    end
  end

  assign expired   = (state_q == FWD) && (cnt_q == CntWidth'(TimeoutCycles - 1));
  assign timeout_o = timeout_q;
`else
  assign expired   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i) state_d = dec_hit ? FWD : RSP;
      FWD:     if (sel_ready || expired) state_d = RSP;
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            addr_q  <= in_addr_i;
            write_q <= in_write_i;
            wdata_q <= in_wdata_i;
            wstrb_q <= in_wstrb_i;
            sel_q   <= dec_sel;
            rdata_q <= '0;
            error_q <= !dec_hit;
          end
        end
        FWD: begin
          if (sel_ready) begin
            rdata_q <= write_q ? '0 : sel_rdata;
            error_q <= sel_error;
          end else if (expired) begin
            rdata_q <= '0;
            error_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o  = (state_q == RSP);
  assign in_rdata_o  = in_ready_o ? rdata_q : '0;
  assign in_error_o  = in_ready_o & error_q;
  assign out_addr_o  = (state_q == FWD) ? addr_q  : '0;
  assign out_write_o = (state_q == FWD) & write_q;
  assign out_wdata_o = (state_q == FWD) ? wdata_q : '0;
  assign out_wstrb_o = (state_q == FWD) ? wstrb_q : '0;

endmodule

// File: tb/tb_cheshire_reg_demux.sv
// Randomized self-checking bench for cheshire_reg_demux against an address-map reference model.
// Timeout scenarios are exercised when CHESHIRE_REG_DEMUX_TIMEOUT_EN is defined.
module tb_cheshire_reg_demux;

  localparam int NumOut   = 11;
  localparam int NumRules = 6;
  localparam int AW       = 48;
  localparam int DW       = 32;
  localparam int TO       = 8;

  logic                               clk = 1'b0;
  logic                               rst_n;
  logic [NumRules-1:0][32+2*AW-1:0]   addr_map;
  logic [AW-1:0]                      in_addr;
  logic                               in_write;
  logic [DW-1:0]                      in_wdata;
  logic [DW/8-1:0]                    in_wstrb;
  logic                               in_valid;
  logic [DW-1:0]                      in_rdata;
  logic                               in_error;
  logic                               in_ready;
  logic [AW-1:0]                      out_addr;
  logic                               out_write;
  logic [DW-1:0]                      out_wdata;
  logic [DW/8-1:0]                    out_wstrb;
  logic [NumOut-1:0]                  out_valid;
  logic [NumOut-1:0][DW-1:0]          out_rdata;
  logic [NumOut-1:0]                  out_error;
  logic [NumOut-1:0]                  out_ready;
  logic                               timeout;

  int            ri [NumRules];
  logic [AW-1:0] rs [NumRules];
  logic [AW-1:0] re [NumRules];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int r = 0; r < NumRules; r++) addr_map[r] = {32'(ri[r]), rs[r], re[r]};
  end

  cheshire_reg_demux #(
    .NumOut(NumOut), .NumRules(NumRules), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .addr_map_i(addr_map),
    .in_addr_i(in_addr), .in_write_i(in_write), .in_wdata_i(in_wdata), .in_wstrb_i(in_wstrb),
    .in_valid_i(in_valid), .in_rdata_o(in_rdata), .in_error_o(in_error), .in_ready_o(in_ready),
    .out_addr_o(out_addr), .out_write_o(out_write), .out_wdata_o(out_wdata), .out_wstrb_o(out_wstrb),
    .out_valid_o(out_valid), .out_rdata_i(out_rdata), .out_error_i(out_error), .out_ready_i(out_ready),
    .timeout_o(timeout)
  );

  // Scan rules from the top: the first match found is the winner; out-of-range ports are misses.
  function automatic int model_port(input logic [AW-1:0] a);
    for (int r = NumRules - 1; r >= 0; r--)
      if (rs[r] < re[r] && a >= rs[r] && a < re[r]) return (ri[r] < NumOut) ? ri[r] : -1;
    return -1;
  endfunction

  // Upstream driver plus a slave that answers on whichever port is valid after w wait cycles.
  task automatic run_txn(input logic [AW-1:0] a, input logic wr, input logic [DW-1:0] wd,
                         input logic [DW/8-1:0] ws, input int w, input bit b2b,
                         output int lat, output logic [DW-1:0] rd, output logic er,
                         output int vcyc, output logic [NumOut-1:0] vmask,
                         output int bad, output int tocnt);
    lat = -1; rd = '0; er = 1'b0; vcyc = 0; vmask = '0; bad = 0; tocnt = 0;
    in_addr = a; in_write = wr; in_wdata = wd; in_wstrb = ws;
    in_valid = b2b;
    out_ready = '0;
    @(negedge clk);
    if (in_ready !== 1'b0 || out_valid !== '0 || out_addr !== '0 || out_write !== 1'b0 ||
        out_wdata !== '0 || out_wstrb !== '0 || in_rdata !== '0 || in_error !== 1'b0) bad++;
    in_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (timeout === 1'b1) tocnt++;
      if (out_valid !== '0) begin
        vcyc++;
        vmask |= out_valid;
        if ($countones(out_valid) != 1 || out_addr !== a || out_write !== wr ||
            out_wdata !== wd || out_wstrb !== ws) bad++;
      end
      if (in_ready === 1'b1) begin
        lat = c; rd = in_rdata; er = in_error;
        break;
      end
      if (in_rdata !== '0 || in_error !== 1'b0) bad++;
      out_ready = NumOut'($urandom) & ~out_valid;
      if (out_valid !== '0 && vcyc == w + 1) out_ready |= out_valid;
    end
    out_ready = '0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_write = 1'b0; in_wdata = '0; in_wstrb = '0;
    out_ready = '0; out_error = '0;
    for (int p = 0; p < NumOut; p++) out_rdata[p] = $urandom;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_rdata, in_error, in_ready, out_addr, out_write, out_wdata, out_wstrb, out_valid, timeout} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got ready=%b valid=%h rdata=%h addr=%h, required all zero",
               in_ready, out_valid, in_rdata, out_addr);
    end
  endtask

  task automatic test_read();
    int lat, vc, bad, tc; logic [DW-1:0] rd; logic er; logic [NumOut-1:0] vm;
    out_rdata[4] = 32'hCAFE_0001; out_error[4] = 1'b0;
    run_txn(48'h0200_3000, 1'b0, $urandom, 4'hF, 0, 1'b0, lat, rd, er, vc, vm, bad, tc);
    checks++; if (lat != 2) begin errors++; $display("[TB] FAIL read_latency: got %0d required 2", lat); end
    checks++; if (vm !== 11'h010 || vc != 1) begin errors++; $display("[TB] FAIL read_valid: got mask %h for %0d cycles required 010 for 1", vm, vc); end
    checks++; if (rd !== 32'hCAFE_0001 || er !== 1'b0) begin errors++; $display("[TB] FAIL read_data: got %h/%b required cafe0001/0", rd, er); end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL read_protocol: got %0d bad cycles required 0", bad); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL read_ready_pulse: got %b required 0", in_ready); end
  endtask

  task automatic test_write();
    int lat, vc, bad, tc; logic [DW-1:0] rd; logic er; logic [NumOut-1:0] vm;
    out_rdata[0] = 32'hDEAD_BEEF; out_error[0] = 1'b0;
    run_txn(48'h0100_0000, 1'b1, 32'h1234_5678, 4'hF, 3, 1'b0, lat, rd, er, vc, vm, bad, tc);
    checks++; if (lat != 5) begin errors++; $display("[TB] FAIL write_latency: got %0d required 5", lat); end
    checks++; if (vm !== 11'h001 || vc != 4) begin errors++; $display("[TB] FAIL write_valid: got mask %h for %0d cycles required 001 for 4", vm, vc); end
    checks++; if (rd !== '0 || er !== 1'b0) begin errors++; $display("[TB] FAIL write_resp: got %h/%b required 0/0", rd, er); end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL write_stable: got %0d bad cycles required 0", bad); end
  endtask

  task automatic test_unmapped();
    int lat, vc, bad, tc; logic [DW-1:0] rd; logic er; logic [NumOut-1:0] vm;
    run_txn(48'h6000_0000, 1'b0, '0, 4'hF, 0, 1'b0, lat, rd, er, vc, vm, bad, tc);
    checks++; if (lat != 1) begin errors++; $display("[TB] FAIL miss_latency: got %0d required 1", lat); end
    checks++; if (vm !== '0 || vc != 0) begin errors++; $display("[TB] FAIL miss_valid: got mask %h required 0", vm); end
    checks++; if (rd !== '0 || er !== 1'b1 || bad != 0) begin errors++; $display("[TB] FAIL miss_resp: got %h/%b bad=%0d required 0/1 bad=0", rd, er, bad); end
  endtask

  // Directed decode boundaries: overlap, end exclusivity, inverted rule, out-of-range winner.
  task automatic test_decode_bounds();
    logic [AW-1:0] addrs [7] = '{48'h800, 48'h1800, 48'h2000, 48'h0200_3FFF, 48'h0200_4000, 48'h0500_0000, 48'h0100_0800};
    int            ports [7] = '{3, 3, -1, 4, -1, -1, -1};
    int lat, vc, bad, tc; logic [DW-1:0] rd; logic er; logic [NumOut-1:0] vm; logic [NumOut-1:0] exp_m;
    for (int i = 0; i < 7; i++) begin
      run_txn(addrs[i], 1'b0, '0, 4'hF, 1, 1'b0, lat, rd, er, vc, vm, bad, tc);
      exp_m = (ports[i] < 0) ? '0 : NumOut'(1) << ports[i];
      checks++;
      if (vm !== exp_m || lat != ((ports[i] < 0) ? 1 : 3) || bad != 0) begin
        errors++;
        $display("[TB] FAIL decode_%h: got mask %h lat %0d bad %0d required mask %h lat %0d",
                 addrs[i], vm, lat, bad, exp_m, (ports[i] < 0) ? 1 : 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, vc, bad, tc; logic [DW-1:0] rd; logic er; logic [NumOut-1:0] vm;
    out_rdata[4] = 32'h0000_4444; out_rdata[3] = 32'h3333_0000; out_error = '0; out_error[3] = 1'b1;
    run_txn(48'h0200_3010, 1'b0, '0, 4'h1, 0, 1'b0, lat, rd, er, vc, vm, bad, tc);
    checks++; if (rd !== 32'h0000_4444 || lat != 2) begin errors++; $display("[TB] FAIL b2b_first: got %h lat %0d required 00004444 lat 2", rd, lat); end
    run_txn(48'h0000_0100, 1'b1, 32'hA5A5_A5A5, 4'h3, 2, 1'b1, lat, rd, er, vc, vm, bad, tc);
    checks++;
    if (lat != 4 || vm !== 11'h008 || rd !== '0 || er !== 1'b1 || bad != 0) begin
      errors++;
      $display("[TB] FAIL b2b_second: got lat %0d mask %h rdata %h err %b bad %0d required 4/008/0/1/0", lat, vm, rd, er, bad);
    end
    run_txn(48'h7000_0000, 1'b0, '0, 4'hF, 0, 1'b1, lat, rd, er, vc, vm, bad, tc);
    checks++;
    if (lat != 1 || vm !== '0 || er !== 1'b1 || bad != 0) begin
      errors++;
      $display("[TB] FAIL b2b_third: got lat %0d mask %h err %b bad %0d required 1/0/1/0", lat, vm, er, bad);
    end
    out_error = '0;
  endtask

  task automatic test_reset_mid();
    int lat, vc, bad, tc; logic [DW-1:0] rd; logic er; logic [NumOut-1:0] vm;
    in_addr = 48'h0200_3004; in_write = 1'b0; in_valid = 1'b1; out_ready = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 11'h010) begin errors++; $display("[TB] FAIL midreset_fwd: got %h required 010", out_valid); end
    rst_n = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== '0 || in_ready !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_drop: got valid %h ready %b required 0/0", out_valid, in_ready);
    end
    rst_n = 1'b1;
    out_rdata[4] = 32'h0BAD_F00D; out_error[4] = 1'b0;
    run_txn(48'h0200_3008, 1'b0, '0, 4'hF, 1, 1'b0, lat, rd, er, vc, vm, bad, tc);
    checks++;
    if (lat != 3 || rd !== 32'h0BAD_F00D || er !== 1'b0 || bad != 0) begin
      errors++;
      $display("[TB] FAIL midreset_next: got lat %0d rdata %h err %b bad %0d required 3/0badf00d/0/0", lat, rd, er, bad);
    end
  endtask

`ifdef CHESHIRE_REG_DEMUX_TIMEOUT_EN
  task automatic test_timeout();
    int lat, vc, bad, tc; logic [DW-1:0] rd; logic er; logic [NumOut-1:0] vm;
    out_rdata[4] = 32'h1111_2222; out_error[4] = 1'b0;
    run_txn(48'h0200_3000, 1'b0, '0, 4'hF, 100, 1'b0, lat, rd, er, vc, vm, bad, tc);
    checks++;
    if (vc != TO || lat != TO + 1 || tc != 1 || er !== 1'b1 || rd !== '0) begin
      errors++;
      $display("[TB] FAIL timeout_expire: got vcyc %0d lat %0d pulses %0d err %b rdata %h required %0d/%0d/1/1/0", vc, lat, tc, er, rd, TO, TO + 1);
    end
    run_txn(48'h0200_3000, 1'b0, '0, 4'hF, TO - 1, 1'b0, lat, rd, er, vc, vm, bad, tc);
    checks++;
    if (vc != TO || lat != TO + 1 || tc != 0 || er !== 1'b0 || rd !== 32'h1111_2222) begin
      errors++;
      $display("[TB] FAIL timeout_last_ready: got vcyc %0d lat %0d pulses %0d err %b rdata %h required %0d/%0d/0/0/11112222", vc, lat, tc, er, rd, TO, TO + 1);
    end
  endtask
`endif

  task automatic test_random();
    int lat, vc, bad, tc, k, w, p, exp_lat, exp_vc; bit to, b2b;
    logic [DW-1:0] rd, exp_rd; logic er, exp_er, wr; logic [NumOut-1:0] vm, exp_m; logic [AW-1:0] a;
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, NumRules - 1);
      case ($urandom_range(0, 4))
        0:       a = rs[k];
        1:       a = re[k] - 1;
        2:       a = re[k];
        3:       a = rs[k] + AW'($urandom_range(0, 'h1FFF));
        default: a = AW'($urandom);
      endcase
`ifdef CHESHIRE_REG_DEMUX_TIMEOUT_EN
      w = $urandom_range(0, TO + 3);
`else
      w = $urandom_range(0, 4);
`endif
      wr = 1'($urandom); b2b = 1'($urandom);
      for (int q = 0; q < NumOut; q++) out_rdata[q] = $urandom;
      out_error = NumOut'($urandom);
      p = model_port(a);
`ifdef CHESHIRE_REG_DEMUX_TIMEOUT_EN
      to = (p >= 0) && (w >= TO);
`else
      to = 1'b0;
`endif
      exp_lat = (p < 0) ? 1 : (to ? TO + 1 : w + 2);
      exp_vc  = (p < 0) ? 0 : (to ? TO : w + 1);
      exp_m   = (p < 0) ? '0 : NumOut'(1) << p;
      exp_rd  = (p < 0 || to || wr) ? '0 : out_rdata[(p < 0) ? 0 : p];
      exp_er  = (p < 0 || to) ? 1'b1 : out_error[(p < 0) ? 0 : p];
      run_txn(a, wr, $urandom, 4'($urandom), w, b2b, lat, rd, er, vc, vm, bad, tc);
      checks++;
      if (lat != exp_lat || vc != exp_vc || vm !== exp_m) begin
        errors++;
        $display("[TB] FAIL rand_route addr %h: got lat %0d vcyc %0d mask %h required %0d/%0d/%h", a, lat, vc, vm, exp_lat, exp_vc, exp_m);
      end
      checks++;
      if (rd !== exp_rd || er !== exp_er || bad != 0 || tc != int'(to)) begin
        errors++;
        $display("[TB] FAIL rand_resp addr %h: got rdata %h err %b bad %0d to %0d required %h/%b/0/%0d", a, rd, er, bad, tc, exp_rd, exp_er, int'(to));
      end
    end
  endtask

  initial begin
    ri = '{0, 15, 1, 2, 4, 3};
    rs = '{48'h0100_0000, 48'h0100_0800, 48'h0, 48'h0500_0000, 48'h0200_3000, 48'h0};
    re = '{48'h0100_1000, 48'h0100_2000, 48'h1000, 48'h0400_0000, 48'h0200_4000, 48'h2000};
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_decode_bounds();
    test_back_to_back();
    test_reset_mid();
`ifdef CHESHIRE_REG_DEMUX_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
